// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file writeback types and constants
package rf_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] xlen_t;

    typedef struct packed {
        reg_idx_t rd;
        xlen_t    data;
    } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - synchronous FIFO buffering long-unit writeback results
import rf_pkg::*;

module wb_result_fifo #(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t        mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - RF write-port arbiter and long-op scoreboard; starvation guard under RF_WB_STARVE_GUARD_EN
import rf_pkg::*;

module rf_writeback_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_rd,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rd_d,
    output logic        hazard_stall,
    output logic        pipe_hold,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic [31:0] pending
);

    localparam logic [NUM_REGS-1:0] X0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

    wb_req_t             head;
    wb_req_t             push_req;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                pipe_own;
    logic                fifo_grant;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    assign lu_ready  = !rst & !fifo_full;
    assign fifo_push = lu_valid & lu_ready;
    assign push_req  = '{rd: lu_rd, data: lu_data};

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_req),
        .pop       (fifo_grant),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    // x0 writes from the pipeline are dropped, leaving the port to the FIFO.
    assign pipe_own   = pipe_we & (pipe_rd != '0) & !pipe_hold;
    assign fifo_grant = !rst & !pipe_own & !fifo_empty;
    assign rf_we      = !rst & (pipe_own | (fifo_grant & (head.rd != '0)));

    always_comb begin
        rf_rd    = pipe_rd;
        rf_wdata = pipe_data;
        if (!pipe_own && !fifo_empty) begin
            rf_rd    = head.rd;
            rf_wdata = head.data;
        end
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (lu_issue)
            set_vec[lu_issue_rd] = 1'b1;
        if (fifo_grant)
            clr_vec[head.rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending_q <= '0;
        else
            pending_q <= ((pending_q & ~clr_vec) | set_vec) & X0_MASK;
    end

    assign pending      = pending_q;
    assign hazard_stall = pending_q[rs1_d] | pending_q[rs2_d] | pending_q[rd_d];

`ifdef RF_WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          hold_q;

    // Reaching the limit clears the count and forces one FIFO grant next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            hold_q     <= 1'b0;
        end else begin
            hold_q <= 1'b0;
            if (fifo_empty || fifo_grant) begin
                starve_cnt <= '0;
            end else if (pipe_own) begin
                if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
                    starve_cnt <= '0;
                    hold_q     <= 1'b1;
                end else begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
        end
    end

    assign pipe_hold = hold_q;
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign pipe_hold           = 1'b0;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - self-checking bench for rf_writeback_arbiter
module tb_rf_writeback_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk, rst;
    logic        pipe_we, lu_issue, lu_valid;
    logic [4:0]  pipe_rd, lu_issue_rd, lu_rd, rs1_d, rs2_d, rd_d;
    logic [31:0] pipe_data, lu_data;
    logic        lu_ready, hazard_stall, pipe_hold, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata, pending;

    int checks = 0;
    int errors = 0;

    ent_t        q[$];
    logic [31:0] m_pend;
    logic        m_hold;
    int          m_starve;
    logic        e_pown, e_grant, e_ready, e_nonempty;

    rf_writeback_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .lu_issue     (lu_issue),
        .lu_issue_rd  (lu_issue_rd),
        .lu_valid     (lu_valid),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rd_d         (rd_d),
        .hazard_stall (hazard_stall),
        .pipe_hold    (pipe_hold),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pend   = '0;
        m_hold   = 1'b0;
        m_starve = 0;
    endtask

    task automatic set_in(input logic we, input logic [4:0] prd, input logic [31:0] pd,
                          input logic iss, input logic [4:0] ird,
                          input logic v, input logic [4:0] lrd, input logic [31:0] ld,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        pipe_we = we;  pipe_rd = prd;  pipe_data = pd;
        lu_issue = iss; lu_issue_rd = ird;
        lu_valid = v;  lu_rd = lrd;    lu_data = ld;
        rs1_d = s1;    rs2_d = s2;     rd_d = d;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Expected port behaviour derived from the current model state and inputs.
    task automatic eval_check();
        logic e_we;
        e_pown     = pipe_we && (pipe_rd != 0) && !m_hold;
        e_nonempty = (q.size() != 0);
        e_grant    = !e_pown && e_nonempty;
        e_ready    = (q.size() < DEPTH);
        e_we       = e_pown || (e_grant && q[0].rd != 0);
        chk("rf_we", 32'(rf_we), 32'(e_we));
        chk("lu_ready", 32'(lu_ready), 32'(e_ready));
        chk("pending", pending, m_pend);
        chk("hazard_stall", 32'(hazard_stall), 32'(m_pend[rs1_d] | m_pend[rs2_d] | m_pend[rd_d]));
        chk("pipe_hold", 32'(pipe_hold), 32'(m_hold));
        if (e_pown) begin
            chk("rf_rd_pipe", 32'(rf_rd), 32'(pipe_rd));
            chk("rf_wdata_pipe", rf_wdata, pipe_data);
        end else if (e_grant) begin
            chk("rf_rd_fifo", 32'(rf_rd), 32'(q[0].rd));
            chk("rf_wdata_fifo", rf_wdata, q[0].data);
        end
    endtask

    task automatic model_update();
        ent_t e;
        logic hold_next;
        if (e_grant) begin
            e = q.pop_front();
            m_pend[e.rd] = 1'b0;
        end
        if (lu_valid && e_ready) begin
            e.rd = lu_rd;
            e.data = lu_data;
            q.push_back(e);
        end
        if (lu_issue && lu_issue_rd != 0)
            m_pend[lu_issue_rd] = 1'b1;
        hold_next = 1'b0;
`ifdef RF_WB_STARVE_GUARD_EN
        if (e_nonempty && e_pown) begin
            m_starve++;
            if (m_starve == LIMIT) begin
                hold_next = 1'b1;
                m_starve  = 0;
            end
        end else begin
            m_starve = 0;
        end
`endif
        m_hold = hold_next;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        eval_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #3;
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_lu_ready", 32'(lu_ready), 32'd0);
        chk("reset_pending", pending, 32'd0);
        chk("reset_pipe_hold", 32'(pipe_hold), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Idle pipeline: result written one cycle after its push
        set_in(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);           tick();
        set_in(0, 0, 0, 0, 0, 1, 5, 32'h1234, 0, 0, 0);    tick();
        idle(); #1;
        chk("lat_we", 32'(rf_we), 32'd1);
        chk("lat_rd", 32'(rf_rd), 32'd5);
        chk("lat_data", rf_wdata, 32'h1234);
        chk("lat_pend_before", 32'(pending[5]), 32'd1);
        tick(); #1;
        chk("lat_pend_after", 32'(pending[5]), 32'd0);

        // RAW stall held until the cycle after x7 is written
        set_in(0, 0, 0, 1, 7, 0, 0, 0, 7, 0, 0);           tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);           #1;
        chk("raw_stall_1", 32'(hazard_stall), 32'd1);      tick();
        set_in(0, 0, 0, 0, 0, 1, 7, 32'h77, 7, 0, 0);      #1;
        chk("raw_stall_2", 32'(hazard_stall), 32'd1);      tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);           #1;
        chk("raw_stall_wr", 32'(hazard_stall), 32'd1);
        chk("raw_wr_rd", 32'(rf_rd), 32'd7);               tick();
        #1;
        chk("raw_release", 32'(hazard_stall), 32'd0);      tick();
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);           tick();
        #1;
        chk("x0_never_pending", pending, 32'd0);
        chk("x0_no_stall", 32'(hazard_stall), 32'd0);

        // Contention: pipeline first, buffered result next
        set_in(0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0);           tick();
        set_in(0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0);      tick();
        set_in(1, 3, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0);       #1;
        chk("cont_pipe_rd", 32'(rf_rd), 32'd3);
        chk("cont_pipe_data", rf_wdata, 32'hA);            tick();
        idle(); #1;
        chk("cont_fifo_we", 32'(rf_we), 32'd1);
        chk("cont_fifo_rd", 32'(rf_rd), 32'd9);
        chk("cont_fifo_data", rf_wdata, 32'h99);           tick();

        // FIFO full under continuous pipeline writes; third result held
        set_in(0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0);          tick();
        set_in(0, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0);          tick();
        set_in(0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0);          tick();
        set_in(1, 1, 32'h1, 0, 0, 1, 10, 32'h100, 0, 0, 0); tick();
        set_in(1, 1, 32'h2, 0, 0, 1, 11, 32'h101, 0, 0, 0); tick();
        set_in(1, 1, 32'h3, 0, 0, 1, 12, 32'h102, 0, 0, 0); #1;
        chk("full_ready", 32'(lu_ready), 32'd0);           tick();
        begin
            bit taken = 0;
            for (int i = 0; i < 10 && !taken; i++) begin
                set_in(0, 0, 0, 0, 0, 1, 12, 32'h102, 0, 0, 0);
                taken = (q.size() < DEPTH) && !(pipe_we && pipe_rd != 0 && !m_hold);
                tick();
            end
            chk("full_third_taken", 32'(taken), 32'd1);
        end
        idle();
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("full_drained", pending, 32'd0);

        // Starvation: pipeline writes every cycle with one buffered result
        set_in(0, 0, 0, 1, 20, 0, 0, 0, 0, 0, 0);          tick();
        set_in(0, 0, 0, 0, 0, 1, 20, 32'h200, 0, 0, 0);    tick();
        for (int i = 0; i < 8; i++) begin
            set_in(1, 2, 32'(i), 0, 0, 0, 0, 0, 0, 0, 0);  tick();
        end
        idle();
        for (int i = 0; i < 3; i++) tick();

        // Asynchronous reset in the middle of a drain
        set_in(0, 0, 0, 1, 21, 0, 0, 0, 0, 0, 0);          tick();
        set_in(1, 4, 32'h4, 1, 22, 1, 21, 32'h210, 0, 0, 0); tick();
        set_in(1, 4, 32'h4, 0, 0, 1, 22, 32'h220, 0, 0, 0); tick();
        idle();                                            tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_rf_we", 32'(rf_we), 32'd0);
        chk("arst_pending", pending, 32'd0);
        chk("arst_lu_ready", 32'(lu_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_ready_after", 32'(lu_ready), 32'd1);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                   1'($urandom_range(0, 2) == 0), 5'($urandom),
                   1'($urandom_range(0, 2) == 0), 5'($urandom), $urandom,
                   5'($urandom), 5'($urandom), 5'($urandom));
            tick();
        end
        idle();
        for (int i = 0; i < 12; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
